// File: rtl/arb_fifo_sequencer.sv
// Instruction sequencer for one arbitrated FIFO bank. It turns a NOP/PUSH/REQ/HALT stream into
// one-hot push/request pulses, tracks FIFO occupancy in shadow counters and flags status disagreement.
module arb_fifo_sequencer #(
    parameter int NUM_REQS = 2,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int QWID     = 4,
    parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_vld_i,
    input  logic                      cfg_start_i,
    input  logic [NUM_REQS*QWID-1:0]  cfg_quantums_i,
    input  logic                      instr_vld_i,
    input  logic [1:0]                instr_op_i,
    input  logic [IDXW-1:0]           instr_idx_i,
    input  logic [WIDTH-1:0]          instr_data_i,
    output logic                      instr_rdy_o,
    input  logic [NUM_REQS-1:0]       full_i,
    input  logic [NUM_REQS-1:0]       empty_i,
    input  logic [NUM_REQS-1:0]       gnt_i,
    output logic [NUM_REQS-1:0]       push_o,
    output logic [NUM_REQS-1:0]       reqs_o,
    output logic [NUM_REQS*WIDTH-1:0] flat_data_in_o,
    output logic                      start_o,
    output logic [NUM_REQS*QWID-1:0]  quantums_o,
    output logic                      running_o,
    output logic [7:0]                drop_cnt_o,
    output logic                      err_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_REQ  = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                      state_q, state_d;
    logic                        start_q, start_d;
    logic [NUM_REQS*QWID-1:0]    quantums_q, quantums_d;
    logic [NUM_REQS-1:0]         push_q, push_d, reqs_q, reqs_d;
    logic [NUM_REQS*WIDTH-1:0]   data_q, data_d;
    logic [NUM_REQS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [7:0]                  drop_q, drop_d;
    logic                        err_q, err_d;

    logic                        accept, idx_ok, is_push, is_req, push_ok, req_ok;
    logic [NUM_REQS-1:0]         lane_sel, cnt_full, cnt_zero, gnt_ok, gnt_bad, status_bad;

    assign accept  = instr_vld_i && (state_q == ST_RUN);
    assign idx_ok  = (int'(instr_idx_i) < NUM_REQS);
    assign is_push = accept && (instr_op_i == OP_PUSH);
    assign is_req  = accept && (instr_op_i == OP_REQ);
    // Legality uses the pre-edge counters, so a same-edge grant never frees a slot early.
    assign push_ok = is_push && |(lane_sel & ~cnt_full);
    assign req_ok  = is_req && |(lane_sel & ~cnt_zero);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_lane
            assign lane_sel[gi]   = idx_ok && (int'(instr_idx_i) == gi);
            assign cnt_full[gi]   = (cnt_q[gi] == DEPTH_C);
            assign cnt_zero[gi]   = (cnt_q[gi] == '0);
            assign gnt_ok[gi]     = gnt_i[gi] && !cnt_zero[gi];
            assign gnt_bad[gi]    = gnt_i[gi] && cnt_zero[gi];
            assign status_bad[gi] = (full_i[gi] != cnt_full[gi]) || (empty_i[gi] != cnt_zero[gi]);
            assign cnt_d[gi] = (push_d[gi] && !gnt_ok[gi]) ? cnt_q[gi] + 1'b1 :
                               (!push_d[gi] && gnt_ok[gi]) ? cnt_q[gi] - 1'b1 : cnt_q[gi];
            assign data_d[gi*WIDTH +: WIDTH] = push_d[gi] ? instr_data_i
                                                          : data_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        quantums_d = quantums_q;
        push_d     = '0;
        reqs_d     = '0;
        drop_d     = drop_q;
        err_d      = err_q || (|gnt_bad) || (|status_bad);
        case (state_q)
            ST_IDLE: begin
                if (cfg_vld_i) begin
                    start_d    = cfg_start_i;
                    quantums_d = cfg_quantums_i;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                if (push_ok) push_d = lane_sel;
                if (req_ok)  reqs_d = lane_sel;
                if (((is_push && !push_ok) || (is_req && !req_ok)) && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                if (accept && (instr_op_i == OP_HALT)) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            quantums_q <= '0;
            push_q     <= '0;
            reqs_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            quantums_q <= quantums_d;
            push_q     <= push_d;
            reqs_q     <= reqs_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign instr_rdy_o    = (state_q == ST_RUN);
    assign running_o      = (state_q == ST_RUN);
    assign push_o         = push_q;
    assign reqs_o         = reqs_q;
    assign flat_data_in_o = data_q;
    assign start_o        = start_q;
    assign quantums_o     = quantums_q;
    assign drop_cnt_o     = drop_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_arb_fifo_sequencer.sv
// Bench for arb_fifo_sequencer: a vector table of instructions with expected pulses, plus
// hand sequences for config freeze, HALT, error stickiness and asynchronous reset.
module tb_arb_fifo_sequencer;
    localparam int NR = 2;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int QW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_vld, cfg_start;
    logic [NR*QW-1:0] cfg_quantums;
    logic          instr_vld;
    logic [1:0]    instr_op;
    logic [0:0]    instr_idx;
    logic [W-1:0]  instr_data;
    logic          instr_rdy;
    logic [NR-1:0] full, empty, gnt, push, reqs;
    logic [NR*W-1:0] flat_data_in;
    logic          start, running, err;
    logic [NR*QW-1:0] quantums;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    arb_fifo_sequencer #(.NUM_REQS(NR), .WIDTH(W), .DEPTH(D), .QWID(QW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_vld_i(cfg_vld), .cfg_start_i(cfg_start), .cfg_quantums_i(cfg_quantums),
        .instr_vld_i(instr_vld), .instr_op_i(instr_op), .instr_idx_i(instr_idx),
        .instr_data_i(instr_data), .instr_rdy_o(instr_rdy),
        .full_i(full), .empty_i(empty), .gnt_i(gnt),
        .push_o(push), .reqs_o(reqs), .flat_data_in_o(flat_data_in),
        .start_o(start), .quantums_o(quantums), .running_o(running),
        .drop_cnt_o(drop_cnt), .err_o(err)
    );

    typedef struct {
        logic [1:0] op;
        logic [0:0] idx;
        logic [7:0] data;
        logic [1:0] gnt;
        logic [1:0] exp_push;
        logic [1:0] exp_reqs;
        logic [7:0] exp_drop;
        logic       exp_err;
        logic       exp_run;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int txn = 0;
    vec_t sb_q[$];

    // Reference FIFO occupancy used to drive full/empty, plus expected data lanes.
    int        m_cnt [NR];
    bit        m_run;
    logic [NR*W-1:0] m_flat;

    function automatic vec_t mk(input logic [1:0] op, input logic [0:0] idx, input logic [7:0] data,
                                input logic [1:0] g, input logic [1:0] ep, input logic [1:0] er,
                                input logic [7:0] ed, input logic ee, input logic erun);
        vec_t v;
        v.op = op; v.idx = idx; v.data = data; v.gnt = g;
        v.exp_push = ep; v.exp_reqs = er; v.exp_drop = ed; v.exp_err = ee; v.exp_run = erun;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_status();
        for (int i = 0; i < NR; i++) begin
            full[i]  = (m_cnt[i] == D);
            empty[i] = (m_cnt[i] == 0);
        end
    endtask

    task automatic model_step(input vec_t v);
        int pre [NR];
        for (int i = 0; i < NR; i++) pre[i] = m_cnt[i];
        for (int i = 0; i < NR; i++) begin
            int inc = 0;
            int dec = 0;
            if (m_run && v.op == 2'd1 && int'(v.idx) == i && pre[i] != D) begin
                inc = 1;
                m_flat[i*W +: W] = v.data;
            end
            if (v.gnt[i] && pre[i] > 0) dec = 1;
            m_cnt[i] = pre[i] + inc - dec;
        end
        if (m_run && v.op == 2'd3) m_run = 0;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        instr_vld = 1'b1; instr_op = v.op; instr_idx = v.idx; instr_data = v.data; gnt = v.gnt;
        sb_q.push_back(v);
        @(posedge clk);
        model_step(v);
        #1;
        instr_vld = 1'b0; gnt = '0;
        drive_status();
        e = sb_q.pop_front();
        chk("push", 32'(push), 32'(e.exp_push));
        chk("reqs", 32'(reqs), 32'(e.exp_reqs));
        chk("drop_cnt", 32'(drop_cnt), 32'(e.exp_drop));
        chk("err", 32'(err), 32'(e.exp_err));
        chk("running", 32'(running), 32'(e.exp_run));
        chk("instr_rdy", 32'(instr_rdy), 32'(e.exp_run));
        if (e.exp_push != 2'b00 || e.op == 2'd0) chk("flat_data", 32'(flat_data_in), 32'(m_flat));
        $display("txn %0d op=%0d idx=%0d data=%02h gnt=%b push=%b reqs=%b drop=%0d err=%b run=%b",
                 txn, e.op, e.idx, e.data, e.gnt, push, reqs, drop_cnt, err, running);
        txn++;
    endtask

    task automatic cfg(input logic s, input logic [NR*QW-1:0] q);
        @(negedge clk);
        cfg_vld = 1'b1; cfg_start = s; cfg_quantums = q;
        @(posedge clk);
        m_run = 1;
        #1;
        cfg_vld = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_run = 0;
        m_flat = '0;
        drive_status();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [18];
        for (int k = 0; k < 9; k++)
            tbl[k] = mk(2'd1, 1'b0, 8'(k + 1), 2'b00, (k < 8) ? 2'b01 : 2'b00, 2'b00,
                        (k < 8) ? 8'd0 : 8'd1, 1'b0, 1'b1);
        tbl[9]  = mk(2'd0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'd1, 1'b0, 1'b1);
        tbl[10] = mk(2'd2, 1'b1, 8'h00, 2'b00, 2'b00, 2'b00, 8'd2, 1'b0, 1'b1);
        tbl[11] = mk(2'd1, 1'b1, 8'hA5, 2'b00, 2'b10, 2'b00, 8'd2, 1'b0, 1'b1);
        tbl[12] = mk(2'd2, 1'b1, 8'h00, 2'b00, 2'b00, 2'b10, 8'd2, 1'b0, 1'b1);
        tbl[13] = mk(2'd0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b00, 8'd2, 1'b0, 1'b1);
        tbl[14] = mk(2'd2, 1'b1, 8'h00, 2'b00, 2'b00, 2'b00, 8'd3, 1'b0, 1'b1);
        tbl[15] = mk(2'd2, 1'b0, 8'h00, 2'b00, 2'b00, 2'b01, 8'd3, 1'b0, 1'b1);
        // Full FIFO granted on the same edge: the push is still illegal.
        tbl[16] = mk(2'd1, 1'b0, 8'h66, 2'b01, 2'b00, 2'b00, 8'd4, 1'b0, 1'b1);
        tbl[17] = mk(2'd1, 1'b0, 8'h77, 2'b00, 2'b01, 2'b00, 8'd4, 1'b0, 1'b1);

        rst_n = 1'b0; cfg_vld = 1'b0; cfg_start = 1'b0; cfg_quantums = '0;
        instr_vld = 1'b0; instr_op = 2'd0; instr_idx = '0; instr_data = '0; gnt = '0;
        model_reset();
        #1;
        chk("rst_push", 32'(push), 32'h0);
        chk("rst_reqs", 32'(reqs), 32'h0);
        chk("rst_data", 32'(flat_data_in), 32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_quantums", 32'(quantums), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_rdy", 32'(instr_rdy), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Configuration latch, then freeze while running.
        cfg(1'b1, 8'h21);
        chk("cfg_start", 32'(start), 32'h1);
        chk("cfg_quantums", 32'(quantums), 32'h21);
        chk("cfg_running", 32'(running), 32'h1);
        chk("cfg_rdy", 32'(instr_rdy), 32'h1);
        cfg(1'b0, 8'h55);
        chk("frozen_quantums", 32'(quantums), 32'h21);
        chk("frozen_start", 32'(start), 32'h1);

        for (int k = 0; k < 18; k++) apply(tbl[k]);
        chk("full0_model", 32'(full), 32'h1);

        // HALT, then an instruction presented while idle is ignored.
        apply(mk(2'd3, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'd4, 1'b0, 1'b0));
        apply(mk(2'd1, 1'b1, 8'h11, 2'b00, 2'b00, 2'b00, 8'd4, 1'b0, 1'b0));
        chk("halt_quantums", 32'(quantums), 32'h21);
        chk("halt_start", 32'(start), 32'h1);
        cfg(1'b0, 8'h34);
        chk("recfg_quantums", 32'(quantums), 32'h34);
        chk("recfg_start", 32'(start), 32'h0);
        chk("recfg_running", 32'(running), 32'h1);
        // FIFO 0 shadow count survived HALT, so this push is dropped.
        apply(mk(2'd1, 1'b0, 8'h22, 2'b00, 2'b00, 2'b00, 8'd5, 1'b0, 1'b1));

        // Grant on an empty FIFO sets a sticky error.
        apply(mk(2'd0, 1'b0, 8'h00, 2'b10, 2'b00, 2'b00, 8'd5, 1'b1, 1'b1));
        apply(mk(2'd0, 1'b0, 8'h00, 2'b00, 2'b00, 2'b00, 8'd5, 1'b1, 1'b1));
        apply(mk(2'd0, 1'b0, 8'h00, 2'b01, 2'b00, 2'b00, 8'd5, 1'b1, 1'b1));
        apply(mk(2'd1, 1'b0, 8'h3C, 2'b00, 2'b01, 2'b00, 8'd5, 1'b1, 1'b1));

        // Asynchronous reset while push[0] is high.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_push", 32'(push), 32'h0);
        chk("arst_data", 32'(flat_data_in), 32'h0);
        chk("arst_quantums", 32'(quantums), 32'h0);
        chk("arst_running", 32'(running), 32'h0);
        chk("arst_drop", 32'(drop_cnt), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_running", 32'(running), 32'h0);
        chk("post_rst_rdy", 32'(instr_rdy), 32'h0);
        chk("post_rst_err", 32'(err), 32'h0);

        if (sb_q.size() != 0) chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
